// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response handshake plus word-addressed data memory port of the
// load/store controller. The controller takes the slave view; the pipeline/memory side takes master.
interface lsu_mem_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wr_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wr_data_i;
    logic        resp_valid_o;
    logic [31:0] resp_rd_data_o;
    logic        resp_err_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_wr_data_o;
    logic [3:0]  mem_byte_en_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_valid_i;

    modport slave (
        input  req_valid_i, req_wr_i, req_funct3_i, req_addr_i, req_wr_data_i,
        input  mem_rd_data_i, mem_valid_i,
        output req_ready_o, resp_valid_o, resp_rd_data_o, resp_err_o,
        output mem_req_o, mem_addr_o, mem_wr_en_o, mem_wr_data_o, mem_byte_en_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_funct3_i, req_addr_i, req_wr_data_i,
        output mem_rd_data_i, mem_valid_i,
        input  req_ready_o, resp_valid_o, resp_rd_data_o, resp_err_o,
        input  mem_req_o, mem_addr_o, mem_wr_en_o, mem_wr_data_o, mem_byte_en_o
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller: one request at a time, word-boundary crossings split into
// two word accesses, per-access timeout and illegal-funct3 error responses.
module lsu_mem_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic        ready_q;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;
    logic        wr_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] w0_q;
    logic [31:0] w1_q;

    logic        accept;
    logic        illegal_req;
    logic        split;
    logic [1:0]  offset;
    logic [2:0]  size;
    logic [3:0]  end_pos;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [63:0] lane_data;
    logic [31:0] shifted_rd;
    logic [31:0] load_data;

    assign accept      = bus.req_valid_i && ready_q;
    assign illegal_req = (bus.req_funct3_i == 3'b011) || (bus.req_funct3_i[2:1] == 2'b11) ||
                         (bus.req_wr_i && bus.req_funct3_i[2]);

    // Access geometry is derived from the latched request so it stays stable while waiting
    assign offset = addr_q[1:0];

    always_comb begin
        size      = 3'd4;
        size_mask = 4'b1111;
        case (funct3_q[1:0])
            2'b00: begin
                size      = 3'd1;
                size_mask = 4'b0001;
            end
            2'b01: begin
                size      = 3'd2;
                size_mask = 4'b0011;
            end
            default: begin
                size      = 3'd4;
                size_mask = 4'b1111;
            end
        endcase
    end

    assign end_pos = {2'b00, offset} + {1'b0, size};
    assign split   = end_pos > 4'd4;

    // Lanes of the second word are whatever spills past bit 31 of the first
    assign lane_mask  = {4'b0000, size_mask} << offset;
    assign lane_data  = {32'h0, wr_data_q} << {offset, 3'b000};
    assign shifted_rd = 32'({w1_q, w0_q} >> {offset, 3'b000});

    always_comb begin
        load_data = shifted_rd;
        case (size)
            3'd1: load_data = funct3_q[2] ? {24'h0, shifted_rd[7:0]}
                                          : {{24{shifted_rd[7]}}, shifted_rd[7:0]};
            3'd2: load_data = funct3_q[2] ? {16'h0, shifted_rd[15:0]}
                                          : {{16{shifted_rd[15]}}, shifted_rd[15:0]};
            default: load_data = shifted_rd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= 32'h0;
            wr_data_q <= 32'h0;
            w0_q      <= 32'h0;
            w1_q      <= 32'h0;
        end else begin
            if (accept) begin
                wr_q      <= bus.req_wr_i;
                funct3_q  <= bus.req_funct3_i;
                addr_q    <= bus.req_addr_i;
                wr_data_q <= bus.req_wr_data_i;
                w0_q      <= 32'h0;
                w1_q      <= 32'h0;
            end
            if (state_q == ACC0 && bus.mem_valid_i) w0_q <= bus.mem_rd_data_i;
            if (state_q == ACC1 && bus.mem_valid_i) w1_q <= bus.mem_rd_data_i;
        end
    end

    // The wait counter is allowed to reach WAIT_LIMIT, so an access is held MAX_WAIT+1 cycles
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                wait_d = 8'd0;
                if (accept) begin
                    err_d   = illegal_req;
                    state_d = illegal_req ? RESP : ACC0;
                end
            end
            ACC0: begin
                if (bus.mem_valid_i) begin
                    wait_d  = 8'd0;
                    state_d = split ? ACC1 : RESP;
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ACC1: begin
                if (bus.mem_valid_i) begin
                    wait_d  = 8'd0;
                    state_d = RESP;
                end else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                wait_d  = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_req_o     = 1'b0;
        bus.mem_addr_o    = 32'h0;
        bus.mem_wr_en_o   = 1'b0;
        bus.mem_wr_data_o = 32'h0;
        bus.mem_byte_en_o = 4'b0000;
        if (state_q == ACC0) begin
            bus.mem_req_o     = 1'b1;
            bus.mem_addr_o    = {addr_q[31:2], 2'b00};
            bus.mem_wr_en_o   = wr_q;
            bus.mem_wr_data_o = lane_data[31:0];
            bus.mem_byte_en_o = lane_mask[3:0];
        end else if (state_q == ACC1) begin
            bus.mem_req_o     = 1'b1;
            bus.mem_addr_o    = {addr_q[31:2] + 30'd1, 2'b00};
            bus.mem_wr_en_o   = wr_q;
            bus.mem_wr_data_o = lane_data[63:32];
            bus.mem_byte_en_o = lane_mask[7:4];
        end
    end

    assign bus.req_ready_o    = ready_q;
    assign bus.resp_valid_o   = (state_q == RESP);
    assign bus.resp_err_o     = (state_q == RESP) && err_q;
    assign bus.resp_rd_data_o = (state_q == RESP && !err_q && !wr_q) ? load_data : 32'h0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected memory accesses and
// responses; a memory responder and a response monitor pop and compare independently.
module tb_lsu_mem_ctrl;
    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } mem_exp_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          edge_at;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    int edge_cnt = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int next_id  = 0;
    int acc_idx  = 0;
    bit mem_busy = 1'b0;
    int mem_cnt  = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectAccess(input logic [31:0] addr, input logic [3:0] be, input logic wr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        mem_exp_t m;
        m.addr  = addr;
        m.be    = be;
        m.wr    = wr;
        m.wdata = wdata;
        m.rdata = rdata;
        m.waits = waits;
        mem_q.push_back(m);
    endtask

    // Response is expected during the cycle lat cycles after the accept edge
    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit expect_resp,
                                 input logic [31:0] exp_data, input logic exp_err, input int lat);
        int k = 0;
        resp_exp_t e;
        @(negedge clk);
        while (bus.req_ready_o !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput($sformatf("req%0d ready before issue", next_id), 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i   = 1'b1;
        bus.req_wr_i      = wr;
        bus.req_funct3_i  = f3;
        bus.req_addr_i    = addr;
        bus.req_wr_data_i = wdata;
        if (expect_resp) begin
            e.id      = next_id;
            e.data    = exp_data;
            e.err     = exp_err;
            e.edge_at = edge_cnt + lat;
            resp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput($sformatf("req%0d ready after accept", next_id), 32'(bus.req_ready_o), 32'd0);
        next_id++;
        bus.req_valid_i   = 1'b0;
        bus.req_wr_i      = ~wr;
        bus.req_funct3_i  = 3'b111;
        bus.req_addr_i    = ~addr;
        bus.req_wr_data_i = ~wdata;
    endtask

    task automatic waitIdle();
        int k = 0;
        while ((resp_q.size() != 0 || bus.req_ready_o !== 1'b1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("resp queue drained", 32'(resp_q.size()), 32'd0);
        checkOutput("mem queue drained", 32'(mem_q.size()), 32'd0);
        resp_q.delete();
        mem_q.delete();
    endtask

    // Memory model: picks up each new access, checks its fields, then answers after its wait count
    initial begin : mem_responder
        mem_exp_t cur;
        bus.mem_valid_i   = 1'b0;
        bus.mem_rd_data_i = 32'h5A5A5A5A;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_valid_i   = 1'b0;
            bus.mem_rd_data_i = 32'h5A5A5A5A;
            if (!rst_n || bus.mem_req_o !== 1'b1) begin
                mem_busy = 1'b0;
            end else begin
                if (!mem_busy) begin
                    checkOutput($sformatf("acc%0d expected", acc_idx), 32'(mem_q.size() > 0), 32'd1);
                    if (mem_q.size() > 0) begin
                        cur = mem_q.pop_front();
                        checkOutput($sformatf("acc%0d mem_addr", acc_idx), bus.mem_addr_o, cur.addr);
                        checkOutput($sformatf("acc%0d mem_byte_en", acc_idx), 32'(bus.mem_byte_en_o), 32'(cur.be));
                        checkOutput($sformatf("acc%0d mem_wr_en", acc_idx), 32'(bus.mem_wr_en_o), 32'(cur.wr));
                        checkOutput($sformatf("acc%0d mem_wr_data", acc_idx), bus.mem_wr_data_o, cur.wdata);
                    end else begin
                        cur.rdata = 32'h0;
                        cur.waits = 0;
                    end
                    acc_idx++;
                    mem_busy = 1'b1;
                    mem_cnt  = cur.waits;
                end
                if (mem_cnt == 0) begin
                    bus.mem_valid_i   = 1'b1;
                    bus.mem_rd_data_i = cur.rdata;
                    mem_busy          = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
        end
    end

    initial begin : resp_monitor
        resp_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid_o === 1'b1) begin
                checkOutput("response expected", 32'(resp_q.size() > 0), 32'd1);
                if (resp_q.size() > 0) begin
                    e = resp_q.pop_front();
                    checkOutput($sformatf("resp%0d data", e.id), bus.resp_rd_data_o, e.data);
                    checkOutput($sformatf("resp%0d err", e.id), 32'(bus.resp_err_o), 32'(e.err));
                    checkOutput($sformatf("resp%0d cycle", e.id), 32'(edge_cnt), 32'(e.edge_at));
                end
            end
        end
    end

    initial begin
        rst_n             = 1'b0;
        bus.req_valid_i   = 1'b0;
        bus.req_wr_i      = 1'b0;
        bus.req_funct3_i  = 3'b000;
        bus.req_addr_i    = 32'h0;
        bus.req_wr_data_i = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", 32'(bus.req_ready_o), 32'd0);
        checkOutput("reset resp_valid", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("reset resp_err", 32'(bus.resp_err_o), 32'd0);
        checkOutput("reset resp_rd_data", bus.resp_rd_data_o, 32'd0);
        checkOutput("reset mem_req", 32'(bus.mem_req_o), 32'd0);
        checkOutput("reset mem_addr", bus.mem_addr_o, 32'd0);
        checkOutput("reset mem_byte_en", 32'(bus.mem_byte_en_o), 32'd0);
        checkOutput("reset mem_wr_en", 32'(bus.mem_wr_en_o), 32'd0);
        checkOutput("reset mem_wr_data", bus.mem_wr_data_o, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready before first edge", 32'(bus.req_ready_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ready after first edge", 32'(bus.req_ready_o), 32'd1);

        $display("[TB] aligned and lane-selected loads");
        expectAccess(32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
        expectAccess(32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h80FF_0000, 0);
        applyStimulus(1'b0, 3'b000, 32'h0000_0203, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 2);
        expectAccess(32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h80FF_0000, 0);
        applyStimulus(1'b0, 3'b100, 32'h0000_0203, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 2);
        expectAccess(32'h0000_0100, 4'b1100, 1'b0, 32'h0, 32'h8001_1234, 0);
        applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0, 1'b1, 32'h0000_8001, 1'b0, 2);
        expectAccess(32'h0000_0100, 4'b0011, 1'b0, 32'h0, 32'hFFFF_7FFF, 2);
        applyStimulus(1'b0, 3'b001, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_7FFF, 1'b0, 4);

        $display("[TB] stores and split accesses");
        expectAccess(32'h0000_0104, 4'b1110, 1'b1, 32'h2233_4400, 32'h5555_5555, 0);
        expectAccess(32'h0000_0108, 4'b0001, 1'b1, 32'h0000_0011, 32'h5555_5555, 0);
        applyStimulus(1'b1, 3'b010, 32'h0000_0105, 32'h1122_3344, 1'b1, 32'h0, 1'b0, 3);
        expectAccess(32'h0000_0100, 4'b0100, 1'b1, 32'h00A5_0000, 32'h5555_5555, 0);
        applyStimulus(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00A5, 1'b1, 32'h0, 1'b0, 2);
        expectAccess(32'h0000_01FC, 4'b1000, 1'b0, 32'h0, 32'hAB00_0000, 0);
        expectAccess(32'h0000_0200, 4'b0001, 1'b0, 32'h0, 32'h0000_00CD, 3);
        applyStimulus(1'b0, 3'b001, 32'h0000_01FF, 32'h0, 1'b1, 32'hFFFF_CDAB, 1'b0, 6);
        expectAccess(32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0, 32'h5678_0000, 0);
        expectAccess(32'h0000_0000, 4'b0011, 1'b0, 32'h0, 32'h0000_1234, 0);
        applyStimulus(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 3);

        $display("[TB] timeout and illegal codes");
        expectAccess(32'h0000_0400, 4'b1111, 1'b0, 32'h0, 32'h1111_1111, 255);
        applyStimulus(1'b0, 3'b010, 32'h0000_0400, 32'h0, 1'b1, 32'h0, 1'b1, 6);
        applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 3'b110, 32'h0000_0100, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        applyStimulus(1'b1, 3'b100, 32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0, 1'b1, 1);
        waitIdle();

        $display("[TB] reset during access");
        expectAccess(32'h0000_0300, 4'b1111, 1'b0, 32'h0, 32'hDEAD_0000, 255);
        applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clk);
        checkOutput("mem_req before reset", 32'(bus.mem_req_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mem_req at reset", 32'(bus.mem_req_o), 32'd0);
        checkOutput("resp_valid at reset", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("ready at reset", 32'(bus.req_ready_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready before edge after reset", 32'(bus.req_ready_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ready one edge after reset", 32'(bus.req_ready_o), 32'd1);
        repeat (6) @(negedge clk);

        expectAccess(32'h0000_0500, 4'b1111, 1'b0, 32'h0, 32'h0BAD_F00D, 1);
        applyStimulus(1'b0, 3'b010, 32'h0000_0500, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 3);
        waitIdle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
